uart_bridge: RTL
================

UART_BRIDGE -- requirements
Module: uart_bridge

Interface
REQ-001 Parameter: RXQ_DEPTH, default 16, receive queue depth in bytes; power of two, 2..256.
REQ-002 Port: clk  input  1  system clock; all logic on rising edge.
REQ-003 Port: rstn  input  1  reset, asynchronous, active-low.
REQ-004 Port: uart_go  input  1  one-cycle request pulse from the core control FSM.
REQ-005 Port: rors  input  1  request kind, sampled with uart_go: 1 = send byte, 0 = receive byte.
REQ-006 Port: send_data  input  8  byte to transmit, sampled with uart_go.
REQ-007 Port: uart_done  output  1  one-cycle completion pulse back to the core.
REQ-008 Port: recv_data  output  8  last received byte; held stable between receive completions.
REQ-009 Port: tx_valid / tx_byte / tx_ready  output 1 / output 8 / input 1  byte handshake to the UART transmitter.
REQ-010 Port: rx_valid / rx_byte  input 1 / input 8  one-cycle byte strobe from the UART receiver.
REQ-011 Port: rx_overflow  output  1  sticky flag: a received byte was dropped.

Function
REQ-012 The FSM SHALL have states IDLE, TX_REQ, RX_WAIT, DONE.
REQ-013 IDLE: uart_go&rors -> TX_REQ, latching send_data; uart_go&!rors -> RX_WAIT; else stay.
REQ-014 TX_REQ: tx_valid=1 and tx_byte=latched byte, both registered; -> DONE on the tx_valid&tx_ready cycle, else hold (tx_byte stable).
REQ-015 RX_WAIT: if queue non-empty, pop head into recv_data and go to DONE; else stay.
REQ-016 DONE: uart_done=1 for exactly one cycle; then -> IDLE.
REQ-017 Send latency: uart_go at cycle N with tx_ready=1 SHALL give tx_valid at N+1 and uart_done at N+2.
REQ-018 Receive latency: uart_go at N with a non-empty queue SHALL give recv_data updated and uart_done at N+2.
REQ-019 uart_go outside IDLE SHALL be ignored; no queuing of requests.
REQ-020 Receive queue SHALL capture every rx_valid byte independent of FSM state, FIFO order.
REQ-021 Push while full without simultaneous pop SHALL drop the byte and set rx_overflow; the queue is unchanged.
REQ-022 Push and pop in the same cycle when full SHALL both take effect; no overflow.
REQ-023 Push into empty queue while in RX_WAIT SHALL not pop the same cycle; pop occurs next cycle (uart_done one cycle later).
REQ-024 Queue pointers SHALL wrap modulo RXQ_DEPTH; count width clog2(RXQ_DEPTH)+1.
REQ-025 recv_data SHALL change only on a pop.

Reset
REQ-026 rstn low SHALL immediately force: state IDLE, tx_valid 0, tx_byte 0, uart_done 0, recv_data 0, queue empty, rx_overflow 0.
REQ-027 Reset mid-transaction SHALL abandon it without a uart_done pulse; a pending tx handshake is withdrawn.

Configuration
REQ-028 Macro UART_BRIDGE_STATS_EN defined: add outputs tx_cnt[15:0] (accepted tx handshakes) and rx_cnt[15:0] (bytes pushed, drops excluded), wrapping, reset to 0.
REQ-029 Macro undefined: those ports and counters SHALL be absent; all other behaviour identical.

Structure
REQ-030 Package uart_bridge_pkg SHALL hold the FSM state enum and request-kind constants (SEND=1, RECV=0).
REQ-031 The receive queue SHALL be a sub-module rx_fifo (sync FIFO, push/pop/full/empty, same clock and reset).

Verification
REQ-032 Send 0x5A, tx_ready=1 -> tx_valid@N+1 with tx_byte=0x5A, uart_done@N+2 only, tx_cnt=1.
REQ-033 Send 0xA3, tx_ready low 5 cycles -> tx_valid held, tx_byte=0xA3 stable, uart_done 1 cycle after ready.
REQ-034 Push 0x11,0x22 then two receives -> recv_data 0x11 then 0x22, one uart_done each.
REQ-035 Receive on empty queue, rx_byte 0x7E at +10 -> uart_done 2 cycles after strobe, recv_data=0x7E.
REQ-036 Push 17 bytes (depth 16), no pops -> rx_overflow=1, 16 receives return bytes 1..16, rx_cnt=16.
REQ-037 rstn low while in TX_REQ -> tx_valid 0 same cycle, no uart_done, queue empty after release.

Source files
------------

// File: rtl/uart_bridge_pkg.sv
// uart_bridge_pkg: shared types for the UART bridge (FSM state encoding and
// request-kind constants sampled with uart_go).
package uart_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TX_REQ  = 2'd1,
        ST_RX_WAIT = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // Value of rors that selects each request kind
    localparam logic REQ_SEND = 1'b1;
    localparam logic REQ_RECV = 1'b0;

endpackage

// File: rtl/rx_fifo.sv
// rx_fifo: single-clock byte FIFO for the UART receive path. Head byte is
// presented combinationally on dout. A push while full is dropped unless a
// pop happens in the same cycle; every drop sets the sticky overflow flag.
module rx_fifo
    import uart_bridge_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty,
    output logic       overflow
);

    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_overflow;

    logic          w_push_ok;
    logic          w_pop_ok;

    assign full      = (r_count == CNT_FULL);
    assign empty     = (r_count == '0);
    assign w_pop_ok  = pop && !empty;
    assign w_push_ok = push && (!full || w_pop_ok);
    assign dout      = r_mem[r_rd_ptr];
    assign overflow  = r_overflow;

    // Storage array; no reset needed since occupancy is tracked by r_count
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); occupancy and drop flag
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push_ok && !w_pop_ok) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push_ok && w_pop_ok) begin
                r_count <= r_count - 1'b1;
            end
            if (push && !w_push_ok) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_bridge.sv
// uart_bridge: turns one-cycle send/receive requests from the core into a
// tx_valid/tx_ready handshake or a pop from the receive queue, answering
// with a one-cycle uart_done pulse.
// Optional build macro UART_BRIDGE_STATS_EN adds tx_cnt/rx_cnt counters.
module uart_bridge
    import uart_bridge_pkg::*;
#(
    parameter int unsigned RXQ_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        uart_go,
    input  logic        rors,
    input  logic [7:0]  send_data,
    output logic        uart_done,
    output logic [7:0]  recv_data,
    output logic        tx_valid,
    output logic [7:0]  tx_byte,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    output logic        rx_overflow
`ifdef UART_BRIDGE_STATS_EN
    ,
    output logic [15:0] tx_cnt,
    output logic [15:0] rx_cnt
`endif
);

    state_t     r_state;
    state_t     w_state_nx;
    logic       r_tx_valid;
    logic [7:0] r_tx_byte;
    logic       r_uart_done;
    logic [7:0] r_recv_data;

    logic       w_latch_tx;
    logic       w_pop;
    logic [7:0] w_fifo_dout;
    logic       w_fifo_full;
    logic       w_fifo_empty;

    rx_fifo #(
        .DEPTH (RXQ_DEPTH)
    ) u_rx_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .push     (rx_valid),
        .din      (rx_byte),
        .pop      (w_pop),
        .dout     (w_fifo_dout),
        .full     (w_fifo_full),
        .empty    (w_fifo_empty),
        .overflow (rx_overflow)
    );

    assign tx_valid  = r_tx_valid;
    assign tx_byte   = r_tx_byte;
    assign uart_done = r_uart_done;
    assign recv_data = r_recv_data;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state decode, tx byte capture and queue pop request
    always_comb begin
        w_state_nx = r_state;
        w_latch_tx = 1'b0;
        w_pop      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (uart_go && rors == REQ_SEND) begin
                    w_state_nx = ST_TX_REQ;
                    w_latch_tx = 1'b1;
                end else if (uart_go && rors == REQ_RECV) begin
                    w_state_nx = ST_RX_WAIT;
                end
            end
            ST_TX_REQ: begin
                if (r_tx_valid && tx_ready) begin
                    w_state_nx = ST_DONE;
                end
            end
            ST_RX_WAIT: begin
                // empty is registered, so a byte pushed this cycle pops next cycle
                if (!w_fifo_empty) begin
                    w_pop      = 1'b1;
                    w_state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nx = ST_IDLE;
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    // Registered outputs derived from the upcoming state and captured data
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_tx_valid  <= 1'b0;
            r_tx_byte   <= '0;
            r_uart_done <= 1'b0;
            r_recv_data <= '0;
        end else begin
            r_tx_valid  <= (w_state_nx == ST_TX_REQ);
            r_uart_done <= (w_state_nx == ST_DONE);
            if (w_latch_tx) begin
                r_tx_byte <= send_data;
            end
            if (w_pop) begin
                r_recv_data <= w_fifo_dout;
            end
        end
    end

`ifdef UART_BRIDGE_STATS_EN
    logic [15:0] r_tx_cnt;
    logic [15:0] r_rx_cnt;

    assign tx_cnt = r_tx_cnt;
    assign rx_cnt = r_rx_cnt;

    // Accepted tx handshakes and accepted (non-dropped) receive bytes
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_tx_cnt <= '0;
            r_rx_cnt <= '0;
        end else begin
            if (r_tx_valid && tx_ready) begin
                r_tx_cnt <= r_tx_cnt + 1'b1;
            end
            if (rx_valid && (!w_fifo_full || w_pop)) begin
                r_rx_cnt <= r_rx_cnt + 1'b1;
            end
        end
    end
`endif

endmodule
